csr_access_arbiter: RTL and testbench
=====================================

# csr_access_arbiter

Shares the single CSR read-modify-write port of the CSR unit between two requesters: the memory-execution pipeline (pipe) and a host/debug agent (dbg). Grants one access at a time with round-robin fairness, drives csrWE/csrNumber/csrCode/csrWriteIn for exactly one cycle per access, and returns the captured csrReadOut to the winner. Sits between MemoryExecutionStage/debug logic and CSR_Unit. Holds off any access while a trap or interrupt is being taken, because the CSR unit updates mepc/mcause in that cycle.

## Interface
- NUM_WIDTH, 12, CSR number width (CSR_NumberPath)
- CODE_WIDTH, 3, CSR operation code width (CSR_Code)
- DATA_WIDTH, 32, CSR data width (DataPath)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pipe_req / dbg_req  in  1  access request; held high until the matching ack
- pipe_num / dbg_num  in  NUM_WIDTH  CSR number; stable while req is high
- pipe_code / dbg_code  in  CODE_WIDTH  operation code
- pipe_we / dbg_we  in  1  access writes the CSR
- pipe_wdata / dbg_wdata  in  DATA_WIDTH  write operand
- pipe_flush  in  1  kill a not-yet-performed pipe access
- pipe_ack / dbg_ack  out  1  one-cycle completion pulse
- rdata  out  DATA_WIDTH  old CSR value; valid while ack is high
- trap_busy  in  1  triggerExcpt OR triggerInterrupt
- csr_we  out  1  to csrWE
- csr_num  out  NUM_WIDTH  to csrNumber
- csr_code  out  CODE_WIDTH  to csrCode
- csr_wdata  out  DATA_WIDTH  to csrWriteIn
- csr_rdata  in  DATA_WIDTH  from csrReadOut, combinational on csr_num

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if trap_busy=1, grant nothing. Otherwise:
  - One requester high: grant it.
  - Both high: grant the one not granted last. The last-grant pointer resets to dbg, so pipe wins the first tie.
  - On grant: latch num, code, we, and wdata into operand registers, record the owner, update the pointer, go to ISSUE.
  - A pipe request with pipe_flush=1 in the same cycle is not granted.
- ISSUE:
  - If trap_busy=1: drive csr_we=0 and stay in ISSUE.
  - Else if owner=pipe and pipe_flush=1: return to IDLE with no ack and no write. The pointer update stands.
  - Else: drive csr_num/csr_code/csr_wdata from the operand registers and csr_we=latched we, capture csr_rdata into rdata, go to RESP.
- RESP: pulse the owner's ack for one cycle with rdata stable, then go to IDLE. pipe_flush in RESP is ignored, since the access is already performed.
- csr_num/csr_code/csr_wdata keep their last values outside ISSUE. csr_we is 1 only in a performing ISSUE cycle.
- Exactly one CSR write per granted, unflushed access. Never two writes, never a write during trap_busy.
- rst low (at any time, including mid-access):
  - State goes to IDLE, all outputs 0, pointer to dbg.
  - An in-flight access is dropped without ack. The requester re-issues.

## Timing
- Best-case latency: req high in cycle 0 (IDLE) → CSR write in cycle 1 → ack in cycle 2.
- Throughput: one access per 3 cycles. The next grant can occur in the cycle after RESP.
- A requester deasserts req, or presents a new request, in the cycle after it sees ack. Req held high there is treated as a new request.
- Each trap_busy cycle in ISSUE adds one cycle of latency. There is no timeout.
- rdata is registered and is not combinational from csr_rdata.

## Configuration
- RSD_CSR_ARB_DEBUG_PORT_EN defined: dbg port is functional and arbitration is round-robin as above.
- RSD_CSR_ARB_DEBUG_PORT_EN undefined:
  - dbg_* inputs are ignored and dbg_ack is tied 0.
  - The pointer logic is removed, and pipe is granted whenever it requests and trap_busy=0.
  - Latency and all other behaviour are unchanged.

## Test plan
- Single pipe write, pipe_num=0x340, pipe_wdata=0xDEADBEEF, we=1, csr_rdata=0x12 → csr_we high for exactly cycle 1 with csr_num=0x340 and csr_wdata=0xDEADBEEF; pipe_ack in cycle 2 with rdata=0x12.
- Both requests held for 4 accesses → grant order pipe, dbg, pipe, dbg; exactly 4 csr_we pulses; acks 3 cycles apart.
- trap_busy high for 5 cycles starting in the ISSUE cycle → csr_we stays 0 for those 5 cycles; write occurs in the cycle after trap_busy falls; ack one cycle later.
- pipe_flush asserted in ISSUE with trap_busy=1 → no csr_we, no pipe_ack, back to IDLE; a dbg request then completes normally.
- rst driven low in ISSUE → all outputs 0 immediately; after release, re-issued pipe access completes in 3 cycles.
- Macro undefined, dbg_req held high with pipe idle → dbg_ack never asserts and csr_we stays 0.

Source files
------------

// File: rtl/csr_access_arbiter.sv
// Arbitrates the single CSR read-modify-write port between the pipe and dbg requesters.
// Optional feature macro: RSD_CSR_ARB_DEBUG_PORT_EN (dbg port + round-robin); undefined = pipe only.
module csr_access_arbiter #(
    parameter int NUM_WIDTH  = 12,
    parameter int CODE_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_req,
    input  logic [NUM_WIDTH-1:0]  pipe_num,
    input  logic [CODE_WIDTH-1:0] pipe_code,
    input  logic                  pipe_we,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    input  logic                  pipe_flush,
    output logic                  pipe_ack,
    input  logic                  dbg_req,
    input  logic [NUM_WIDTH-1:0]  dbg_num,
    input  logic [CODE_WIDTH-1:0] dbg_code,
    input  logic                  dbg_we,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  trap_busy,
    output logic                  csr_we,
    output logic [NUM_WIDTH-1:0]  csr_num,
    output logic [CODE_WIDTH-1:0] csr_code,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [1:0]            fsm_state
);
    // Handshake: req is held high with stable operands until its one-cycle ack; in the cycle
    // after ack the requester drops req or presents a new access (a held req is a new access).

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  owner_dbg;
    logic [NUM_WIDTH-1:0]  op_num;
    logic [CODE_WIDTH-1:0] op_code;
    logic                  op_we;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic                  pipe_ok;
    logic                  grant_pipe;
    logic                  grant_dbg;
    logic                  perform;
    logic                  resp_ack;

    // A pipe request that is being flushed in the same cycle is never granted.
    assign pipe_ok = pipe_req && !pipe_flush;

`ifdef RSD_CSR_ARB_DEBUG_PORT_EN
    logic last_dbg;

    always_comb begin
        grant_pipe = 1'b0;
        grant_dbg  = 1'b0;
        if (state == IDLE && !trap_busy) begin
            if (pipe_ok && dbg_req) begin
                grant_pipe = last_dbg;
                grant_dbg  = !last_dbg;
            end else begin
                grant_pipe = pipe_ok;
                grant_dbg  = dbg_req;
            end
        end
    end

    // Pointer starts at dbg so the first tie goes to pipe; a later flush does not undo it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dbg <= 1'b1;
        end else if (grant_pipe) begin
            last_dbg <= 1'b0;
        end else if (grant_dbg) begin
            last_dbg <= 1'b1;
        end
    end

    assign dbg_ack = resp_ack && owner_dbg;
`else
    logic unused_dbg;

    assign grant_pipe = (state == IDLE) && !trap_busy && pipe_ok;
    assign grant_dbg  = 1'b0;
    assign dbg_ack    = 1'b0;
    assign unused_dbg = ^{dbg_req, dbg_num, dbg_code, dbg_we, dbg_wdata};
`endif

    always_comb begin
        state_next = state;
        perform    = 1'b0;
        resp_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_pipe || grant_dbg) state_next = ISSUE;
            end
            ISSUE: begin
                // trap_busy outranks the flush: the CSR unit is busy with mepc/mcause.
                if (trap_busy) begin
                    state_next = ISSUE;
                end else if (!owner_dbg && pipe_flush) begin
                    state_next = IDLE;
                end else begin
                    perform    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_ack   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_dbg <= 1'b0;
            op_num    <= '0;
            op_code   <= '0;
            op_we     <= 1'b0;
            op_wdata  <= '0;
            rdata     <= '0;
        end else begin
            state <= state_next;
            if (grant_pipe || grant_dbg) begin
                owner_dbg <= grant_dbg;
                op_num    <= grant_dbg ? dbg_num   : pipe_num;
                op_code   <= grant_dbg ? dbg_code  : pipe_code;
                op_we     <= grant_dbg ? dbg_we    : pipe_we;
                op_wdata  <= grant_dbg ? dbg_wdata : pipe_wdata;
            end
            if (perform) rdata <= csr_rdata;
        end
    end

    // Operand registers only change on a grant, so the CSR bus holds its value outside ISSUE.
    assign csr_we    = perform && op_we;
    assign csr_num   = op_num;
    assign csr_code  = op_code;
    assign csr_wdata = op_wdata;
    assign pipe_ack  = resp_ack && !owner_dbg;
    assign fsm_state = state;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: directed timing cases plus randomized traffic against a CSR shadow model.
// Builds with or without RSD_CSR_ARB_DEBUG_PORT_EN, matching the design build.
module tb_csr_access_arbiter;
    localparam int NW = 12;
    localparam int CW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipe_req = 1'b0, pipe_we = 1'b0, pipe_flush = 1'b0;
    logic [NW-1:0] pipe_num = '0;
    logic [CW-1:0] pipe_code = '0;
    logic [DW-1:0] pipe_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [NW-1:0] dbg_num = '0;
    logic [CW-1:0] dbg_code = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          trap_busy = 1'b0;
    logic          pipe_ack, dbg_ack, csr_we;
    logic [DW-1:0] rdata, csr_wdata, csr_rdata;
    logic [NW-1:0] csr_num;
    logic [CW-1:0] csr_code;
    logic [1:0]    fsm_state;

    csr_access_arbiter #(.NUM_WIDTH(NW), .CODE_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .pipe_req(pipe_req), .pipe_num(pipe_num), .pipe_code(pipe_code), .pipe_we(pipe_we),
        .pipe_wdata(pipe_wdata), .pipe_flush(pipe_flush), .pipe_ack(pipe_ack),
        .dbg_req(dbg_req), .dbg_num(dbg_num), .dbg_code(dbg_code), .dbg_we(dbg_we),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .rdata(rdata), .trap_busy(trap_busy),
        .csr_we(csr_we), .csr_num(csr_num), .csr_code(csr_code), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CSR unit stand-in: combinational read on csr_num, write at the clock edge.
    function automatic logic [DW-1:0] csr_init(input int i);
        if (i == 'h340) return 32'h12;
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    logic [DW-1:0] csr_mem [0:4095];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= csr_init(i);
            mem_ready <= 1'b1;
        end else if (csr_we) begin
            csr_mem[csr_num] <= csr_wdata;
        end
    end
    assign csr_rdata = csr_mem[csr_num];

    // Reference: architectural CSR values in program order; pipe and dbg use disjoint numbers.
    logic [DW-1:0] shadow [0:4095];

    typedef struct packed {
        logic          we;
        logic [NW-1:0] num;
        logic [CW-1:0] code;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        logic          wrote;
    } acc_t;

    acc_t pipe_q[$];
    acc_t dbg_q[$];
    int   ack_who[$];
    int   ack_at[$];
    int   cyc = 0, we_cnt = 0, last_we_cyc = 0, last_ack_cyc = 0;
    int   pipe_ack_cnt = 0, dbg_ack_cnt = 0;

    task automatic on_write(input bit d);
        acc_t e;
        n_tests++;
        if ((d ? dbg_q.size() : pipe_q.size()) == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got write num=%0h data=%0h, expected none", csr_num, csr_wdata);
            return;
        end
        e = d ? dbg_q[0] : pipe_q[0];
        check("write_num", csr_num, e.num);
        check("write_code", csr_code, e.code);
        check("write_data", csr_wdata, e.wdata);
        check("write_permitted", {e.we, e.wrote}, 2'b10);
        e.wrote = 1'b1;
        if (d) dbg_q[0] = e;
        else pipe_q[0] = e;
    endtask

    task automatic on_ack(input bit d);
        acc_t e;
        ack_who.push_back(d ? 1 : 0);
        ack_at.push_back(cyc);
        last_ack_cyc = cyc;
        if (d) dbg_ack_cnt++;
        else pipe_ack_cnt++;
        n_tests++;
        if ((d ? dbg_q.size() : pipe_q.size()) == 0) begin
            n_fail++;
            $display("FAIL unexpected_ack: got %s ack, expected none", d ? "dbg" : "pipe");
            return;
        end
        e = d ? dbg_q.pop_front() : pipe_q.pop_front();
        check(d ? "dbg_rdata" : "pipe_rdata", rdata, e.rd);
        check("writes_per_access", e.wrote, e.we);
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst === 1'b1) begin
            if (csr_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                check("write_while_trap", trap_busy, 1'b0);
                on_write(csr_num[NW-1]);
            end
            if (pipe_ack || dbg_ack) check("single_ack", pipe_ack && dbg_ack, 1'b0);
            if (pipe_ack) on_ack(1'b0);
            if (dbg_ack) on_ack(1'b1);
        end
    end

    // Issue one access from posedge+1, wait for its ack, drop req in the following cycle.
    task automatic access(input bit d, input logic [NW-1:0] num, input logic [CW-1:0] code,
                          input logic we, input logic [DW-1:0] wd, output int lat);
        acc_t e;
        e.we = we; e.num = num; e.code = code; e.wdata = wd; e.rd = shadow[num]; e.wrote = 1'b0;
        if (we) shadow[num] = wd;
        if (d) begin
            dbg_q.push_back(e);
            dbg_num = num; dbg_code = code; dbg_we = we; dbg_wdata = wd; dbg_req = 1'b1;
        end else begin
            pipe_q.push_back(e);
            pipe_num = num; pipe_code = code; pipe_we = we; pipe_wdata = wd; pipe_req = 1'b1;
        end
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if ((d ? dbg_ack : pipe_ack) === 1'b1) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
        if (d) dbg_req = 1'b0;
        else pipe_req = 1'b0;
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack in 200 cycles, expected an ack", d ? "dbg" : "pipe");
        end
    endtask

    task automatic rand_stream(input bit d, input int n);
        int            lat;
        logic [NW-1:0] num;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            num = (d ? 12'h800 : 12'h300) + NW'($urandom_range(0, 7));
            access(d, num, CW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, lat);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; pipe_req = 1'b0; dbg_req = 1'b0; pipe_flush = 1'b0; trap_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    logic rand_done = 1'b0;

    initial begin
        int lat, w0, a0;
        for (int i = 0; i < 4096; i++) shadow[i] = csr_init(i);

        repeat (3) @(posedge clk);
        #1;
        check("reset_csr_we", csr_we, 0);
        check("reset_csr_num", csr_num, 0);
        check("reset_csr_code", csr_code, 0);
        check("reset_csr_wdata", csr_wdata, 0);
        check("reset_pipe_ack", pipe_ack, 0);
        check("reset_dbg_ack", dbg_ack, 0);
        check("reset_rdata", rdata, 0);
        check("reset_state", fsm_state, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Best case: write in cycle 1, ack in cycle 2 with the old value.
        access(1'b0, 12'h340, 3'h1, 1'b1, 32'hDEAD_BEEF, lat);
        check("single_latency", lat, 2);
        check("write_to_ack_gap", last_ack_cyc - last_we_cyc, 1);
        access(1'b0, 12'h340, 3'h2, 1'b0, 32'h0, lat);
        check("readback_latency", lat, 2);

        // trap_busy over the ISSUE cycle and four more.
        w0 = we_cnt;
        fork
            access(1'b0, 12'h341, 3'h3, 1'b1, 32'h1234_5678, lat);
            begin
                @(posedge clk); #1 trap_busy = 1'b1;
                repeat (5) begin @(posedge clk); #1; end
                trap_busy = 1'b0;
            end
        join
        check("trap_latency", lat, 7);
        check("trap_write_count", we_cnt - w0, 1);
        check("trap_write_to_ack_gap", last_ack_cyc - last_we_cyc, 1);

        // Flush while held in ISSUE by trap_busy: no write, no ack.
        w0 = we_cnt;
        a0 = pipe_ack_cnt;
        pipe_num = 12'h0F0; pipe_code = 3'h1; pipe_we = 1'b1; pipe_wdata = 32'hBAD0_BAD0; pipe_req = 1'b1;
        @(posedge clk); #1;
        trap_busy = 1'b1; pipe_flush = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        trap_busy = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("flush_state_idle", fsm_state, 0);
        pipe_req = 1'b0; pipe_flush = 1'b0;
        @(posedge clk); #1;
        check("flush_no_write", we_cnt - w0, 0);
        check("flush_no_ack", pipe_ack_cnt - a0, 0);
`ifdef RSD_CSR_ARB_DEBUG_PORT_EN
        access(1'b1, 12'h8F0, 3'h2, 1'b1, 32'h0BAD_F00D, lat);
`else
        access(1'b0, 12'h0F1, 3'h2, 1'b1, 32'h0BAD_F00D, lat);
`endif
        check("after_flush_latency", lat, 2);

        // Reset in the ISSUE cycle drops the access; outputs clear at once.
        pipe_num = 12'h345; pipe_code = 3'h6; pipe_we = 1'b1; pipe_wdata = 32'hCAFE_F00D; pipe_req = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_issue", fsm_state, 1);
        rst = 1'b0;
        #1;
        check("rst_csr_we", csr_we, 0);
        check("rst_csr_num", csr_num, 0);
        check("rst_csr_code", csr_code, 0);
        check("rst_csr_wdata", csr_wdata, 0);
        check("rst_acks", {pipe_ack, dbg_ack}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", fsm_state, 0);
        pipe_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 12'h345, 3'h6, 1'b1, 32'hCAFE_F00D, lat);
        check("reissue_latency", lat, 2);

`ifdef RSD_CSR_ARB_DEBUG_PORT_EN
        // Tie from reset: pipe, dbg, pipe, dbg with acks three cycles apart.
        do_reset();
        ack_who.delete();
        ack_at.delete();
        w0 = we_cnt;
        fork
            begin
                int l0;
                access(1'b0, 12'h010, 3'h1, 1'b1, 32'h1111_0000, l0);
                access(1'b0, 12'h011, 3'h1, 1'b1, 32'h1111_0001, l0);
            end
            begin
                int l1;
                access(1'b1, 12'h810, 3'h1, 1'b1, 32'h2222_0000, l1);
                access(1'b1, 12'h811, 3'h1, 1'b1, 32'h2222_0001, l1);
            end
        join
        check("tie_ack_count", ack_who.size(), 4);
        check("tie_write_count", we_cnt - w0, 4);
        if (ack_who.size() == 4) begin
            for (int i = 0; i < 4; i++) check("tie_order", ack_who[i], i % 2);
            for (int i = 1; i < 4; i++) check("tie_spacing", ack_at[i] - ack_at[i-1], 3);
        end
`else
        // dbg port absent: a held dbg request is never served.
        w0 = we_cnt;
        a0 = dbg_ack_cnt;
        dbg_num = 12'h800; dbg_code = 3'h1; dbg_we = 1'b1; dbg_wdata = 32'hFFFF_FFFF; dbg_req = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        dbg_req = 1'b0;
        check("dbg_ignored_ack", dbg_ack_cnt - a0, 0);
        check("dbg_ignored_write", we_cnt - w0, 0);
`endif

        // Randomized traffic with random trap_busy.
        fork
            begin
                fork
                    rand_stream(1'b0, 60);
`ifdef RSD_CSR_ARB_DEBUG_PORT_EN
                    rand_stream(1'b1, 60);
`endif
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    trap_busy = ($urandom_range(0, 4) == 0);
                end
                trap_busy = 1'b0;
            end
`ifndef RSD_CSR_ARB_DEBUG_PORT_EN
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    dbg_req = 1'($urandom_range(0, 1));
                    dbg_num = NW'($urandom);
                    dbg_we = 1'($urandom_range(0, 1));
                    dbg_wdata = $urandom;
                end
                dbg_req = 1'b0;
            end
`endif
        join

        repeat (5) begin @(posedge clk); #1; end
        check("pipe_queue_drained", pipe_q.size(), 0);
        check("dbg_queue_drained", dbg_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
